axi_led_ctrl: RTL

AXI_LED_CTRL -- requirements
Module: axi_led_ctrl

---
 rtl/axi_led_ctrl.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_led_ctrl.sv
// ----------------------------------------------------------------------------
// axi_led_ctrl
// AXI4 slave (64-bit data) holding a small LED register bank. One transaction
// is in flight at a time. Bursts of any type are walked as INCR in 8-byte
// steps. The LEDs either show LED_VAL steadily or blink it against a
// programmable divider.
//
// Ports
//   axi_clk, axi_rst_n   clock, async-assert active-low reset
//   s_axi_aw*/awready    write address channel (size/burst ignored)
//   s_axi_w*/wready      write data channel (wlast ignored, len counts beats)
//   s_axi_b*/bready      write response channel
//   s_axi_ar*/arready    read address channel (size/burst ignored)
//   s_axi_r*/rready      read data channel
//   leds                 registered LED drive
//
// Register map (offset = addr[11:0])
//   0x000 LED_VAL[7:0] RW   0x008 MODE[0] RW (1 = blink)
//   0x010 BLINK_DIV[31:0] RW   0x018 VERSION RO
// ----------------------------------------------------------------------------
module axi_led_ctrl #(
   parameter int         ADDR_W  = 40,
   parameter int         ID_W    = 8,
   parameter logic [7:0] LED_RST = 8'hA5
) (
   input  logic              axi_clk,
   input  logic              axi_rst_n,
   input  logic [ADDR_W-1:0] s_axi_awaddr,
   input  logic [ID_W-1:0]   s_axi_awid,
   input  logic [7:0]        s_axi_awlen,
   input  logic [2:0]        s_axi_awsize,
   input  logic [1:0]        s_axi_awburst,
   input  logic              s_axi_awvalid,
   output logic              s_axi_awready,
   input  logic [63:0]       s_axi_wdata,
   input  logic [7:0]        s_axi_wstrb,
   input  logic              s_axi_wlast,
   input  logic              s_axi_wvalid,
   output logic              s_axi_wready,
   output logic [ID_W-1:0]   s_axi_bid,
   output logic [1:0]        s_axi_bresp,
   output logic              s_axi_bvalid,
   input  logic              s_axi_bready,
   input  logic [ADDR_W-1:0] s_axi_araddr,
   input  logic [ID_W-1:0]   s_axi_arid,
   input  logic [7:0]        s_axi_arlen,
   input  logic [2:0]        s_axi_arsize,
   input  logic [1:0]        s_axi_arburst,
   input  logic              s_axi_arvalid,
   output logic              s_axi_arready,
   output logic [63:0]       s_axi_rdata,
   output logic [ID_W-1:0]   s_axi_rid,
   output logic [1:0]        s_axi_rresp,
   output logic              s_axi_rlast,
   output logic              s_axi_rvalid,
   input  logic              s_axi_rready,
   output logic [7:0]        leds
);

   typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;

   localparam logic [63:0]       VERSION   = 64'h0000_0000_0001_005A;
   localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(8);
   localparam logic [1:0]        RESP_OKAY = 2'b00;
   localparam logic [1:0]        RESP_SLV  = 2'b10;

   state_t            state_reg;
   logic              idle_reg;      // IDLE and out of reset: address readies may rise
   logic              grant_rd_reg;  // winner of the next AW/AR conflict
   logic [ADDR_W-1:0] addr_reg;      // write: current beat addr; read: next beat addr
   logic [ID_W-1:0]   id_reg;
   logic [7:0]        len_reg;
   logic [7:0]        beat_reg;
   logic              err_reg;
   logic [1:0]        bresp_reg;
   logic [63:0]       rdata_reg;
   logic [1:0]        rresp_reg;
   logic              rlast_reg;
   logic [7:0]        led_val_reg;
   logic              mode_reg;
   logic [31:0]       div_reg;
   logic [31:0]       cnt_reg;
   logic              phase_reg;
   logic [7:0]        leds_reg;

   // Address channel arbitration: with both valid, only the granted ready rises.
   logic ar_pick, aw_pick, aw_hs, ar_hs, w_hs, w_map;
   logic [11:0] w_off;
   assign ar_pick       = s_axi_arvalid && (!s_axi_awvalid || grant_rd_reg);
   assign aw_pick       = s_axi_awvalid && (!s_axi_arvalid || !grant_rd_reg);
   assign s_axi_awready = idle_reg && !ar_pick;
   assign s_axi_arready = idle_reg && !aw_pick;
   assign aw_hs         = s_axi_awvalid && s_axi_awready;
   assign ar_hs         = s_axi_arvalid && s_axi_arready;
   assign s_axi_wready  = (state_reg == WDATA);
   assign w_hs          = s_axi_wvalid && s_axi_wready;
   assign w_off         = addr_reg[11:0];
   assign w_map         = (w_off == 12'h000) || (w_off == 12'h008) ||
                          (w_off == 12'h010) || (w_off == 12'h018);

   assign s_axi_bvalid = (state_reg == WRESP);
   assign s_axi_bid    = id_reg;
   assign s_axi_bresp  = bresp_reg;
   assign s_axi_rvalid = (state_reg == RDATA);
   assign s_axi_rid    = id_reg;
   assign s_axi_rdata  = rdata_reg;
   assign s_axi_rresp  = rresp_reg;
   assign s_axi_rlast  = rlast_reg;
   assign leds         = leds_reg;

   logic unused_sigs;
   assign unused_sigs = ^{s_axi_awsize, s_axi_awburst, s_axi_wlast, s_axi_arsize,
                          s_axi_arburst, s_axi_wdata[63:32], s_axi_wstrb[7:4]};

   // Byte-lane merge for the RW registers.
   logic [7:0]  led_wr_data;
   logic [31:0] div_wr_data;
   assign led_wr_data = s_axi_wstrb[0] ? s_axi_wdata[7:0] : led_val_reg;
   for (genvar gi = 0; gi < 4; gi++) begin : g_div_lane
      assign div_wr_data[gi*8 +: 8] = s_axi_wstrb[gi] ? s_axi_wdata[gi*8 +: 8]
                                                      : div_reg[gi*8 +: 8];
   end

   // Read mux: first beat comes straight from araddr, later beats from addr_reg.
   logic [11:0] rd_off;
   logic [63:0] rd_word;
   logic        rd_err;
   always_comb begin
      rd_off  = (state_reg == RDATA) ? addr_reg[11:0] : s_axi_araddr[11:0];
      rd_word = '0;
      rd_err  = 1'b0;
      case (rd_off)
         12'h000: rd_word = {56'd0, led_val_reg};
         12'h008: rd_word = {63'd0, mode_reg};
         12'h010: rd_word = {32'd0, div_reg};
         12'h018: rd_word = VERSION;
         default: rd_err  = 1'b1;
      endcase
   end

   always_ff @(posedge axi_clk or negedge axi_rst_n) begin
      if (!axi_rst_n) begin
         state_reg    <= IDLE;
         idle_reg     <= 1'b0;
         grant_rd_reg <= 1'b1;
         addr_reg     <= '0;
         id_reg       <= '0;
         len_reg      <= '0;
         beat_reg     <= '0;
         err_reg      <= 1'b0;
         bresp_reg    <= RESP_OKAY;
         rdata_reg    <= '0;
         rresp_reg    <= RESP_OKAY;
         rlast_reg    <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               idle_reg <= 1'b1;
               if (aw_hs) begin
                  idle_reg  <= 1'b0;
                  state_reg <= WDATA;
                  addr_reg  <= s_axi_awaddr;
                  id_reg    <= s_axi_awid;
                  len_reg   <= s_axi_awlen;
                  beat_reg  <= '0;
                  err_reg   <= 1'b0;
                  if (s_axi_arvalid) grant_rd_reg <= 1'b1;
               end else if (ar_hs) begin
                  idle_reg  <= 1'b0;
                  state_reg <= RDATA;
                  addr_reg  <= s_axi_araddr + ADDR_STEP;
                  id_reg    <= s_axi_arid;
                  len_reg   <= s_axi_arlen;
                  beat_reg  <= '0;
                  rdata_reg <= rd_word;
                  rresp_reg <= rd_err ? RESP_SLV : RESP_OKAY;
                  rlast_reg <= (s_axi_arlen == 8'd0);
                  if (s_axi_awvalid) grant_rd_reg <= 1'b0;
               end
            end
            WDATA: begin
               if (w_hs) begin
                  addr_reg <= addr_reg + ADDR_STEP;
                  beat_reg <= beat_reg + 8'd1;
                  err_reg  <= err_reg || !w_map;
                  if (beat_reg == len_reg) begin
                     state_reg <= WRESP;
                     bresp_reg <= (err_reg || !w_map) ? RESP_SLV : RESP_OKAY;
                  end
               end
            end
            WRESP: begin
               if (s_axi_bready) begin
                  state_reg <= IDLE;
                  idle_reg  <= 1'b1;
               end
            end
            RDATA: begin
               if (s_axi_rready) begin
                  if (rlast_reg) begin
                     state_reg <= IDLE;
                     idle_reg  <= 1'b1;
                  end else begin
                     addr_reg  <= addr_reg + ADDR_STEP;
                     beat_reg  <= beat_reg + 8'd1;
                     rdata_reg <= rd_word;
                     rresp_reg <= rd_err ? RESP_SLV : RESP_OKAY;
                     rlast_reg <= ((beat_reg + 8'd1) == len_reg);
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Register bank: only a handshaken W beat may modify it.
   always_ff @(posedge axi_clk or negedge axi_rst_n) begin
      if (!axi_rst_n) begin
         led_val_reg <= LED_RST;
         mode_reg    <= 1'b0;
         div_reg     <= '0;
      end else if (w_hs) begin
         case (w_off)
            12'h000: led_val_reg <= led_wr_data;
            12'h008: if (s_axi_wstrb[0]) mode_reg <= s_axi_wdata[0];
            12'h010: div_reg <= div_wr_data;
            default: ;
         endcase
      end
   end

   // Blink engine: static mode parks cnt=0/phase=1, so enabling blink always
   // starts from a known point.
   always_ff @(posedge axi_clk or negedge axi_rst_n) begin
      if (!axi_rst_n) begin
         cnt_reg   <= '0;
         phase_reg <= 1'b1;
         leds_reg  <= LED_RST;
      end else begin
         if (!mode_reg) begin
            cnt_reg   <= '0;
            phase_reg <= 1'b1;
         end else if (cnt_reg >= div_reg) begin
            cnt_reg   <= '0;
            phase_reg <= !phase_reg;
         end else begin
            cnt_reg <= cnt_reg + 32'd1;
         end
         leds_reg <= phase_reg ? led_val_reg : 8'h00;
      end
   end

endmodule
